sobel_edge_pipe: RTL and testbench

- Parametrised streaming Sobel edge filter. Sits after the greyscale stage in the image-processing path, ahead of the display/VGA write path.
- Accepts one greyscale pixel per valid cycle in raster order and keeps two line buffers to form a 3x3 window.
- Computes Gx and Gy together and outputs |Gx|, |Gy|, or the saturated sum |Gx|+|Gy|, as selected per frame.
- Replaces the fixed vertical/horizontal convolution stage.

---
 rtl/sobel_pkg.sv | 20 ++
 rtl/sobel_line_buffer.sv | 31 +++
 rtl/sobel_edge_pipe.sv | 195 +++++++++++++++++++
 tb/tb_sobel_edge_pipe.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and widths for the streaming Sobel edge filter.
package sobel_pkg;

    // Output selection, latched once per frame on the SOF pixel.
    typedef enum logic [1:0] {
        MODE_GX     = 2'b00,
        MODE_GY     = 2'b01,
        MODE_SUM    = 2'b10,
        MODE_BYPASS = 2'b11
    } sobel_mode_e;

    // Cycles from the accepting edge to the output register.
    localparam int LATENCY = 3;

    // Signed gradient width: partial sums need DATA_W+2 bits, their difference one more.
    function automatic int grad_w(input int data_w);
        return data_w + 3;
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Two cascaded line delays addressed by column, read-before-write.
// tap1 is the pixel one line above the current column, tap2 two lines above.
module sobel_line_buffer #(
    parameter int DATA_W    = 12,
    parameter int IMG_WIDTH = 640,
    localparam int ADDR_W   = $clog2(IMG_WIDTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] tap1,
    output logic [DATA_W-1:0] tap2
);

    logic [DATA_W-1:0] line1 [IMG_WIDTH];
    logic [DATA_W-1:0] line2 [IMG_WIDTH];

    // Old contents are presented during the write cycle.
    assign tap1 = line1[addr];
    assign tap2 = line2[addr];

    // Cascade: the incoming pixel enters line1, line1's old value moves into line2.
    always_ff @(posedge clk) begin
        if (we) begin
            line1[addr] <= din;
            line2[addr] <= line1[addr];
        end
    end

endmodule

// File: rtl/sobel_edge_pipe.sv
// Streaming 3x3 Sobel filter, three register stages, one output per accepted pixel.
// Handshake: iDVAL alone qualifies iDATA/iSOF/iMODE; there is no back-pressure,
// every iDVAL=1 cycle is accepted and every accepted pixel yields exactly one
// oDVAL pulse LATENCY cycles later; iDVAL=0 cycles travel down as bubbles.
module sobel_edge_pipe
    import sobel_pkg::*;
#(
    parameter int DATA_W     = 12,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iSOF,
    input  logic [DATA_W-1:0] iDATA,
    input  logic              iDVAL,
    input  logic [1:0]        iMODE,
    output logic [DATA_W-1:0] oDATA,
    output logic              oDVAL,
    output logic [1:0]        oMODE
);

    localparam int GW    = grad_w(DATA_W);
    localparam int PS_W  = DATA_W + 2;
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [GW-1:0] SAT_MAX = {3'b000, {DATA_W{1'b1}}};

    logic [COL_W-1:0]  col, cur_col;
    logic [ROW_W-1:0]  row, cur_row;
    sobel_mode_e       frame_mode, cur_mode;
    logic [DATA_W-1:0] tap1, tap2;
    logic [DATA_W-1:0] win [3][3];
    logic [DATA_W-1:0] nw  [3][3];

    // SOF forces the accepted pixel to position (0,0) and carries the new mode.
    assign cur_col  = iSOF ? '0 : col;
    assign cur_row  = iSOF ? '0 : row;
    assign cur_mode = iSOF ? sobel_mode_e'(iMODE) : frame_mode;
    assign oMODE    = frame_mode;

    sobel_line_buffer #(.DATA_W(DATA_W), .IMG_WIDTH(IMG_WIDTH)) u_line_buffer (
        .clk  (iCLK),
        .we   (iDVAL),
        .addr (cur_col),
        .din  (iDATA),
        .tap1 (tap1),
        .tap2 (tap2)
    );

    // Raster position of the next pixel; holds through stalls.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            col <= '0;
            row <= '0;
        end else if (iDVAL) begin
            if (cur_col == COL_W'(IMG_WIDTH - 1)) begin
                col <= '0;
                row <= (cur_row == ROW_W'(IMG_HEIGHT - 1)) ? '0 : cur_row + 1'b1;
            end else begin
                col <= cur_col + 1'b1;
                row <= cur_row;
            end
        end
    end

    // Frame mode register, updated only on an accepted SOF pixel.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) frame_mode <= MODE_GX;
        else if (iDVAL && iSOF) frame_mode <= sobel_mode_e'(iMODE);
    end

    // Next window: shift left, new column {two lines up, one line up, current} at the right.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            nw[r][0] = win[r][1];
            nw[r][1] = win[r][2];
        end
        nw[0][2] = tap2;
        nw[1][2] = tap1;
        nw[2][2] = iDATA;
    end

    // Window register, advances only on accepted pixels.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win[r][c] <= '0;
        end else if (iDVAL) begin
            win <= nw;
        end
    end

    function automatic logic [PS_W-1:0] wsum(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b,
                                             input logic [DATA_W-1:0] c);
        return PS_W'(a) + (PS_W'(b) << 1) + PS_W'(c);
    endfunction

    logic                s1_vld, s1_border;
    logic [PS_W-1:0]     s1_right, s1_left, s1_bot, s1_top;
    logic [DATA_W-1:0]   s1_ctr;
    sobel_mode_e         s1_mode;

    // S1: weighted column/row sums of the freshly shifted window.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            s1_vld    <= 1'b0;
            s1_border <= 1'b0;
            s1_right  <= '0;
            s1_left   <= '0;
            s1_bot    <= '0;
            s1_top    <= '0;
            s1_ctr    <= '0;
            s1_mode   <= MODE_GX;
        end else begin
            s1_vld <= iDVAL;
            if (iDVAL) begin
                s1_right  <= wsum(nw[0][2], nw[1][2], nw[2][2]);
                s1_left   <= wsum(nw[0][0], nw[1][0], nw[2][0]);
                s1_bot    <= wsum(nw[2][0], nw[2][1], nw[2][2]);
                s1_top    <= wsum(nw[0][0], nw[0][1], nw[0][2]);
                s1_ctr    <= nw[1][1];
                s1_border <= (cur_row < ROW_W'(2)) || (cur_col < COL_W'(2));
                s1_mode   <= cur_mode;
            end
        end
    end

    logic signed [GW-1:0] gx, gy;
    logic        [GW-1:0] ax_c, ay_c;

    assign gx   = $signed({1'b0, s1_right}) - $signed({1'b0, s1_left});
    assign gy   = $signed({1'b0, s1_bot})   - $signed({1'b0, s1_top});
    assign ax_c = gx[GW-1] ? unsigned'(-gx) : unsigned'(gx);
    assign ay_c = gy[GW-1] ? unsigned'(-gy) : unsigned'(gy);

    logic              s2_vld, s2_border;
    logic [GW-1:0]     s2_ax, s2_ay;
    logic [DATA_W-1:0] s2_ctr;
    sobel_mode_e       s2_mode;

    // S2: gradient magnitudes.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            s2_vld    <= 1'b0;
            s2_border <= 1'b0;
            s2_ax     <= '0;
            s2_ay     <= '0;
            s2_ctr    <= '0;
            s2_mode   <= MODE_GX;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_ax     <= ax_c;
                s2_ay     <= ay_c;
                s2_ctr    <= s1_ctr;
                s2_border <= s1_border;
                s2_mode   <= s1_mode;
            end
        end
    end

    logic [GW-1:0]     sel;
    logic [DATA_W-1:0] res;

    // S3 combinational: mode select, saturation, border zeroing.
    always_comb begin
        sel = '0;
        res = '0;
        case (s2_mode)
            MODE_GX:     sel = s2_ax;
            MODE_GY:     sel = s2_ay;
            MODE_SUM:    sel = s2_ax + s2_ay;
            MODE_BYPASS: sel = GW'(s2_ctr);
            default:     sel = '0;
        endcase
        if (s2_border)          res = '0;
        else if (sel > SAT_MAX) res = SAT_MAX[DATA_W-1:0];
        else                    res = sel[DATA_W-1:0];
    end

    // S3: output register.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oDVAL <= 1'b0;
            oDATA <= '0;
        end else begin
            oDVAL <= s2_vld;
            if (s2_vld) oDATA <= res;
        end
    end

endmodule

// File: tb/tb_sobel_edge_pipe.sv
// Self-checking bench: spatial Sobel reference model feeding an expected queue.
module tb_sobel_edge_pipe;

    localparam int DW = 12;
    localparam int W  = 8;
    localparam int H  = 6;

    logic          iCLK = 1'b0;
    logic          iRST = 1'b0;
    logic          iSOF = 1'b0;
    logic [DW-1:0] iDATA = '0;
    logic          iDVAL = 1'b0;
    logic [1:0]    iMODE = 2'b00;
    logic [DW-1:0] oDATA;
    logic          oDVAL;
    logic [1:0]    oMODE;

    sobel_edge_pipe #(.DATA_W(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .iSOF  (iSOF),
        .iDATA (iDATA),
        .iDVAL (iDVAL),
        .iMODE (iMODE),
        .oDATA (oDATA),
        .oDVAL (oDVAL),
        .oMODE (oMODE)
    );

    // ---------------- clock / reset ----------------
    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            out_cnt  = 0;
    int            img [H][W];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: Sobel over the stored image, centre (r-1,c-1), saturated.
    function automatic int model(input int mode, input int r, input int c);
        int p [3][3];
        int gx, gy, ax, ay, v;
        if (r < 2 || c < 2) return 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                p[i][j] = img[r-2+i][c-2+j];
        gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
        gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        case (mode)
            0:       v = ax;
            1:       v = ay;
            2:       v = ax + ay;
            default: v = p[1][1];
        endcase
        return (v > 4095) ? 4095 : v;
    endfunction

    always @(negedge iCLK) begin
        if (iRST && oDVAL) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
                check("spurious_dval", 32'd1, 32'd0);
            end else begin
                check("data", oDATA, exp_q.pop_front());
                check("latency", cyc - exp_cyc_q.pop_front(), 3);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        iDVAL = 1'b0;
        iSOF  = 1'b0;
        iDATA = DW'($urandom);
        @(posedge iCLK);
        #1;
    endtask

    task automatic drive_pix(input int d, input logic sof, input logic [1:0] m, input int expv);
        iDATA = DW'(d);
        iDVAL = 1'b1;
        iSOF  = sof;
        iMODE = m;
        exp_q.push_back(DW'(expv));
        exp_cyc_q.push_back(cyc);
        @(posedge iCLK);
        #1;
        iDVAL = 1'b0;
        iSOF  = 1'b0;
    endtask

    // Frame from pixel (0,0); iMODE switches to late_mode from row 3 on.
    task automatic drive_frame(input int mode, input int late_mode, input int gap, input int n_pix);
        int r, c;
        for (int idx = 0; idx < n_pix; idx++) begin
            r = idx / W;
            c = idx % W;
            while (gap > 0 && $urandom_range(99) < gap) idle();
            drive_pix(img[r][c], idx == 0, (r >= 3) ? 2'(late_mode) : 2'(mode), model(mode, r, c));
        end
    endtask

    task automatic drain(input string tag, input int out0, input int n_pix);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle();
        repeat (2) idle();
        check({tag, "_drained"}, exp_q.size(), 0);
        check({tag, "_count"}, out_cnt - out0, n_pix);
    endtask

    task automatic run_frame(input string tag, input int mode, input int gap);
        int out0;
        out0 = out_cnt;
        drive_frame(mode, mode, gap, W*H);
        drain(tag, out0, W*H);
    endtask

    task automatic load_img(input int kind);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (kind)
                    0:       img[r][c] = 100;
                    1:       img[r][c] = (c < 4) ? 0 : 200;
                    2:       img[r][c] = (c < 4) ? 0 : 4000;
                    default: img[r][c] = int'($urandom_range(4095));
                endcase
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int out0;
        iRST = 1'b0;
        repeat (3) @(posedge iCLK);
        #1;
        check("rst_odata", oDATA, 0);
        check("rst_odval", oDVAL, 0);
        check("rst_omode", oMODE, 0);
        iRST = 1'b1;
        repeat (2) idle();

        load_img(0);
        for (int m = 0; m < 3; m++) run_frame("flat", m, 0);

        load_img(1);
        run_frame("step_gx", 0, 0);
        check("step_omode", oMODE, 0);
        run_frame("step_gy", 1, 0);
        check("step_gy_omode", oMODE, 1);
        run_frame("step_bypass", 3, 0);

        load_img(2);
        run_frame("sat_sum", 2, 0);

        load_img(1);
        run_frame("stall_gx", 0, 30);
        load_img(3);
        run_frame("stall_rand_sum", 2, 30);
        run_frame("stall_rand_gy", 1, 30);

        // Mode change mid-frame is ignored until the next SOF.
        load_img(1);
        out0 = out_cnt;
        drive_frame(0, 1, 0, W*H);
        drain("latch", out0, W*H);
        check("latch_omode_hold", oMODE, 0);
        out0 = out_cnt;
        drive_frame(1, 1, 0, 1);
        check("latch_omode_new", oMODE, 1);
        drain("latch_first", out0, 1);

        // Resync: partial frame, then a fresh SOF without reset.
        load_img(3);
        out0 = out_cnt;
        drive_frame(2, 2, 0, 30);
        drive_frame(2, 2, 0, W*H);
        drain("resync", out0, 30 + W*H);

        // Reset at row 2, col 5 with pixels in flight.
        load_img(1);
        drive_frame(1, 1, 0, 2*W + 5);
        iRST = 1'b0;
        #1;
        check("midrst_odval", oDVAL, 0);
        check("midrst_odata", oDATA, 0);
        check("midrst_omode", oMODE, 0);
        exp_q.delete();
        exp_cyc_q.delete();
        @(posedge iCLK);
        @(posedge iCLK);
        #1;
        check("midrst_hold_odval", oDVAL, 0);
        iRST = 1'b1;
        out0 = out_cnt;
        repeat (4) idle();
        check("midrst_quiet", out_cnt - out0, 0);
        run_frame("post_rst", 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
